// File: rtl/vx_ipdom_warp_stacks_pkg.sv
// Shared types and constants for the multi-warp IPDOM stack block.
// Op encoding and a log2 helper that never returns zero.
package vx_ipdom_warp_stacks_pkg;

  localparam logic IPDOM_OP_PUSH = 1'b0;
  localparam logic IPDOM_OP_POP  = 1'b1;

  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_ipdom_warp_stacks_if.sv
// Request, response and flush bundle for the IPDOM stack block.
// The scheduler side is master, the stack block is slave.
interface vx_ipdom_warp_stacks_if #(
  parameter int WIDTH = 32,
  parameter int WIDW  = 2
);
  logic             req_valid;
  logic             req_ready;
  logic             req_pop;
  logic [WIDW-1:0]  req_wid;
  logic [WIDTH-1:0] req_q0;
  logic [WIDTH-1:0] req_q1;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDW-1:0]  rsp_wid;
  logic [WIDTH-1:0] rsp_d;
  logic             rsp_first;
  logic             rsp_err;

  logic             clr_valid;
  logic [WIDW-1:0]  clr_wid;

  modport master (
    output req_valid, req_pop, req_wid,
    output req_q0, req_q1,
    output rsp_ready, clr_valid, clr_wid,
    input  req_ready, rsp_valid, rsp_wid,
    input  rsp_d, rsp_first, rsp_err
  );

  modport slave (
    input  req_valid, req_pop, req_wid,
    input  req_q0, req_q1,
    input  rsp_ready, clr_valid, clr_wid,
    output req_ready, rsp_valid, rsp_wid,
    output rsp_d, rsp_first, rsp_err
  );

endinterface

// File: rtl/vx_ipdom_warp_stacks_ctr.sv
// One warp's stack pointer, per-slot set bits and status flags.
// An entry is freed only on its second pop (set bit already 1).
module vx_ipdom_warp_stacks_ctr #(
  parameter int DEPTH = 8,
  parameter int ADDRW = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic           pop,
  input  logic           clr,
  output logic [ADDRW:0] count,
  output logic           top_set,
  output logic           empty,
  output logic           full,
  output logic           overflow
);

  logic [DEPTH-1:0] set_q;
  logic [ADDRW-1:0] top;
  logic [ADDRW-1:0] nxt;

  assign top     = ADDRW'(count - 1'b1);
  assign nxt     = count[ADDRW-1:0];
  assign empty   = (count == '0);
  assign full    = (count == (ADDRW+1)'(DEPTH));
  assign top_set = ~empty & set_q[top];

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        if (full) overflow <= 1'b1;
        else      count    <= count + 1'b1;
      end
      if (pop && top_set) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !clr) begin
      if (push && !full) set_q[nxt] <= 1'b0;
      if (pop && !top_set) set_q[top] <= 1'b1;
    end
  end

endmodule

// File: rtl/vx_ipdom_warp_stacks.sv
// Multi-warp IPDOM reconvergence stacks sharing one RAM.
// Pops are answered one cycle later from a registered read port.
module vx_ipdom_warp_stacks
  import vx_ipdom_warp_stacks_pkg::*;
#(
  parameter int NUM_WARPS = 4,
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int WIDW      = log2up(NUM_WARPS),
  parameter int ADDRW     = log2up(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  vx_ipdom_warp_stacks_if.slave bus,
  output logic [NUM_WARPS-1:0] empty,
  output logic [NUM_WARPS-1:0] full,
  output logic [NUM_WARPS-1:0] overflow
);

  typedef struct packed {
    logic [WIDTH-1:0] q1;
    logic [WIDTH-1:0] q0;
  } entry_t;

  entry_t mem [NUM_WARPS][DEPTH];
  entry_t rd_q;

  logic [ADDRW:0]       cnt [NUM_WARPS];
  logic [NUM_WARPS-1:0] top_set;
  logic [ADDRW-1:0]     wr_slot;
  logic [ADDRW-1:0]     rd_slot;
  logic acc, is_pop, sel_empty, sel_full, sel_set;
  logic do_push, do_pop;

  logic            rsp_valid_q;
  logic [WIDW-1:0] rsp_wid_q;
  logic            rsp_first_q;
  logic            rsp_err_q;

  assign bus.req_ready = ~bus.clr_valid
                       & (~rsp_valid_q | bus.rsp_ready);
  assign acc       = bus.req_valid & bus.req_ready;
  assign is_pop    = (bus.req_pop == IPDOM_OP_POP);
  assign sel_empty = empty[bus.req_wid];
  assign sel_full  = full[bus.req_wid];
  assign sel_set   = top_set[bus.req_wid];
  assign wr_slot   = cnt[bus.req_wid][ADDRW-1:0];
  assign rd_slot   = ADDRW'(cnt[bus.req_wid] - 1'b1);
  assign do_push   = acc & ~is_pop & ~sel_full;
  assign do_pop    = acc & is_pop & ~sel_empty;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_ctr
    logic hit;
    assign hit = (bus.req_wid == WIDW'(w));
    vx_ipdom_warp_stacks_ctr #(
      .DEPTH (DEPTH),
      .ADDRW (ADDRW)
    ) u_ctr (
      .clk      (clk),
      .reset    (reset),
      .push     (acc & ~is_pop & hit),
      .pop      (do_pop & hit),
      .clr      (bus.clr_valid & (bus.clr_wid == WIDW'(w))),
      .count    (cnt[w]),
      .top_set  (top_set[w]),
      .empty    (empty[w]),
      .full     (full[w]),
      .overflow (overflow[w])
    );
  end

  // Read and write never coincide: one request per cycle.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[bus.req_wid][wr_slot] <= entry_t'{bus.req_q1, bus.req_q0};
    if (do_pop)
      rd_q <= mem[bus.req_wid][rd_slot];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
    end else if (acc && is_pop) begin
      rsp_valid_q <= 1'b1;
      rsp_wid_q   <= bus.req_wid;
      rsp_first_q <= ~sel_empty & ~sel_set;
      rsp_err_q   <= sel_empty;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_wid   = rsp_wid_q;
  assign bus.rsp_first = rsp_first_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_d     = rsp_err_q   ? '0 :
                         rsp_first_q ? rd_q.q1 : rd_q.q0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (bus.req_valid) assert (32'(bus.req_wid) < NUM_WARPS);
      if (bus.clr_valid) assert (32'(bus.clr_wid) < NUM_WARPS);
    end
  end

endmodule

// File: tb/tb_vx_ipdom_warp_stacks.sv
// Scoreboard bench for vx_ipdom_warp_stacks.
// Pops queue their expected response; a negedge monitor compares.
module tb_vx_ipdom_warp_stacks;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] empty, full, overflow;

  vx_ipdom_warp_stacks_if #(.WIDTH(32), .WIDW(2)) bus();

  vx_ipdom_warp_stacks #(
    .NUM_WARPS (4),
    .WIDTH     (32),
    .DEPTH     (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .empty    (empty),
    .full     (full),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wid;
    logic [31:0] d;
    logic        first;
    logic        err;
  } exp_t;

  exp_t sbq[$];

  int errors = 0;
  int checks = 0;

  logic [31:0] m_q0 [4][8];
  logic [31:0] m_q1 [4][8];
  bit          m_set [4][8];
  int          m_cnt [4];
  bit          m_ovf [4];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < 4; w++) begin
      m_cnt[w] = 0;
      m_ovf[w] = 0;
    end
  endtask

  task automatic do_req(bit pop, int w, logic [31:0] q0, logic [31:0] q1);
    int n;
    exp_t e;
    int t;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_pop   = pop;
    bus.req_wid   = 2'(w);
    bus.req_q0    = q0;
    bus.req_q1    = q1;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      chk("req_timeout", 0, 1);
      bus.req_valid = 1'b0;
      return;
    end
    if (!pop) begin
      if (m_cnt[w] == 8) m_ovf[w] = 1;
      else begin
        m_q0[w][m_cnt[w]]  = q0;
        m_q1[w][m_cnt[w]]  = q1;
        m_set[w][m_cnt[w]] = 0;
        m_cnt[w]++;
      end
    end else begin
      e.wid = 2'(w);
      if (m_cnt[w] == 0) begin
        e.d = '0; e.first = 0; e.err = 1;
      end else begin
        t = m_cnt[w] - 1;
        e.err = 0;
        if (!m_set[w][t]) begin
          e.d = m_q1[w][t]; e.first = 1;
          m_set[w][t] = 1;
        end else begin
          e.d = m_q0[w][t]; e.first = 0;
          m_cnt[w]--;
        end
      end
      sbq.push_back(e);
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic chk_status(string tag);
    logic [3:0] ee, ff, oo;
    for (int w = 0; w < 4; w++) begin
      ee[w] = (m_cnt[w] == 0);
      ff[w] = (m_cnt[w] == 8);
      oo[w] = m_ovf[w];
    end
    @(negedge clk);
    chk({tag, "_empty"}, 64'(empty), 64'(ee));
    chk({tag, "_full"}, 64'(full), 64'(ff));
    chk({tag, "_ovf"}, 64'(overflow), 64'(oo));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sbq.size()), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.rsp_valid && bus.rsp_ready) begin
      if (sbq.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("rsp_wid", 64'(bus.rsp_wid), 64'(e.wid));
        chk("rsp_d", 64'(bus.rsp_d), 64'(e.d));
        chk("rsp_first", 64'(bus.rsp_first), 64'(e.first));
        chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
      end
    end
  end

  initial begin
    logic [31:0] held;
    reset = 1'b1;
    bus.req_valid = 0; bus.req_pop = 0; bus.req_wid = 0;
    bus.req_q0 = 0; bus.req_q1 = 0;
    bus.rsp_ready = 1; bus.clr_valid = 0; bus.clr_wid = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 0);
    chk("rst_empty", 64'(empty), 64'hf);
    chk("rst_full", 64'(full), 0);
    chk("rst_ovf", 64'(overflow), 0);

    // basic push then two pops
    do_req(0, 0, 32'hA0, 32'hA1);
    chk_status("push_w0");
    do_req(1, 0, 0, 0);
    do_req(1, 0, 0, 0);
    drain();
    chk_status("pop_w0");

    // pop on empty stack
    do_req(1, 0, 0, 0);
    drain();
    chk_status("pop_empty");

    // fill w2, overflow, then 16 back-to-back pops
    for (int i = 0; i < 8; i++)
      do_req(0, 2, 32'h200 + 32'(2*i), 32'h201 + 32'(2*i));
    chk_status("fill_w2");
    do_req(0, 2, 32'hDEAD, 32'hBEEF);
    chk_status("ovf_w2");
    for (int i = 0; i < 16; i++) do_req(1, 2, 0, 0);
    drain();
    chk_status("drain_w2");

    // interleaved warps
    do_req(0, 1, 32'h10, 32'h11);
    do_req(0, 3, 32'h30, 32'h31);
    do_req(1, 1, 0, 0);
    do_req(1, 3, 0, 0);
    drain();
    chk_status("interleave");

    // backpressure
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    do_req(1, 1, 0, 0);
    @(negedge clk);
    held = bus.rsp_d;
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", 64'(bus.rsp_valid), 1);
      chk("stall_ready", 64'(bus.req_ready), 0);
      chk("stall_d", 64'(bus.rsp_d), 64'(held));
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    do_req(1, 3, 0, 0);
    drain();
    chk_status("stall");

    // flush w2 holding 5 entries with overflow set
    for (int i = 0; i < 5; i++)
      do_req(0, 2, 32'h500 + 32'(i), 32'h600 + 32'(i));
    chk_status("pre_clr");
    @(negedge clk);
    bus.clr_valid = 1'b1;
    bus.clr_wid   = 2'd2;
    bus.req_valid = 1'b1;
    bus.req_pop   = 1'b0;
    bus.req_wid   = 2'd0;
    #1 chk("clr_req_ready", 64'(bus.req_ready), 0);
    @(posedge clk);
    #1 bus.clr_valid = 1'b0;
    bus.req_valid = 1'b0;
    m_cnt[2] = 0;
    m_ovf[2] = 0;
    chk_status("clr");

    // reset with a response pending
    do_req(0, 0, 32'hC0, 32'hC1);
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    do_req(1, 0, 0, 0);
    @(negedge clk);
    chk("pend_valid", 64'(bus.rsp_valid), 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 chk("rst2_valid", 64'(bus.rsp_valid), 0);
    chk("rst2_empty", 64'(empty), 64'hf);
    chk("rst2_ovf", 64'(overflow), 0);
    sbq.delete();
    model_reset();
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
